// File: rtl/dac_cfg_sequencer_if.sv
// SPI register-write channel between the DAC config sequencer and the SPI master.
interface dac_cfg_sequencer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] spi_reg;
  logic [DATA_W-1:0] spi_data_in;
  logic              spi_send;
  logic              spi_done;
  logic              spi_rw;

  modport master (output spi_reg, spi_data_in, spi_send, spi_rw, input spi_done);
  modport slave  (input spi_reg, spi_data_in, spi_send, spi_rw, output spi_done);
endinterface

// File: rtl/dac_cfg_sequencer.sv
// Multi-channel DAC RCML/RSET configuration sequencer with SPI timeout/retry,
// sticky error reporting and software re-init.
module dac_cfg_sequencer #(
  parameter int unsigned              NUM_CH      = 2,
  parameter int unsigned              FSADJ_W     = 6,
  parameter int unsigned              ADDR_W      = 6,
  parameter int unsigned              DATA_W      = 8,
  parameter logic [NUM_CH*ADDR_W-1:0] RCML_ADDRS  = {6'h08, 6'h05},
  parameter logic [NUM_CH*ADDR_W-1:0] RSET_ADDRS  = {6'h07, 6'h04},
  parameter logic [DATA_W-1:0]        RCML_DATA   = 8'h80,
  parameter int unsigned              TIMEOUT_CYC = 4096,
  parameter int unsigned              MAX_RETRY   = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CH*FSADJ_W-1:0]   dac_fsadj,
  input  logic                        force_reinit,
  dac_cfg_sequencer_if.master         spi,
  output logic                        dac_ready,
  output logic                        cfg_error,
  output logic [2:0]                  err_ch
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CH_W-1:0]    LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_BEGIN, S_RCML_START, S_RCML_WAIT, S_RSET_SCAN,
    S_RSET_START, S_RSET_WAIT, S_IDLE, S_ERROR
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [CH_W-1:0]             r_ch, w_ch_nxt;
  logic [NUM_CH-1:0]           r_mask, w_mask_nxt;
  logic [NUM_CH*FSADJ_W-1:0]   r_shadow, w_shadow_nxt;
  logic [RETRY_W-1:0]          r_retry, w_retry_nxt;
  logic [TMO_W-1:0]            r_tmo, w_tmo_nxt;
  logic [ADDR_W-1:0]           r_spi_reg, w_spi_reg_nxt;
  logic [DATA_W-1:0]           r_spi_data, w_spi_data_nxt;
  logic                        r_spi_send, w_spi_send_nxt;
  logic                        r_cfg_error, w_cfg_error_nxt;
  logic [2:0]                  r_err_ch, w_err_ch_nxt;
  logic                        r_pend, w_pend_nxt;

  logic [NUM_CH-1:0]           w_changed;
  logic [DATA_W-1:0]           w_rset_data;
  logic                        w_done;
  logic                        w_last;
  logic                        w_tmo_hit;

  assign w_done    = spi.spi_done && !r_spi_send;
  assign w_last    = (r_ch == LAST_CH);
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  always_comb begin
    w_changed = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      w_changed[c] = (dac_fsadj[c*FSADJ_W +: FSADJ_W] != r_shadow[c*FSADJ_W +: FSADJ_W]);
  end

  always_comb begin
    w_rset_data                = '0;
    w_rset_data[FSADJ_W-1:0]   = r_shadow[r_ch*FSADJ_W +: FSADJ_W];
    w_rset_data[DATA_W-1]      = 1'b1;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ch_nxt        = r_ch;
    w_mask_nxt      = r_mask;
    w_shadow_nxt    = r_shadow;
    w_retry_nxt     = r_retry;
    w_tmo_nxt       = r_tmo;
    w_spi_reg_nxt   = r_spi_reg;
    w_spi_data_nxt  = r_spi_data;
    w_spi_send_nxt  = 1'b0;
    w_cfg_error_nxt = r_cfg_error;
    w_err_ch_nxt    = r_err_ch;
    w_pend_nxt      = r_pend | force_reinit;

    case (r_state)
      S_BEGIN: begin
        w_mask_nxt  = '1;
        w_ch_nxt    = '0;
        w_state_nxt = S_RCML_START;
      end
      S_RCML_START: begin
        w_spi_reg_nxt  = RCML_ADDRS[r_ch*ADDR_W +: ADDR_W];
        w_spi_data_nxt = RCML_DATA;
        w_spi_send_nxt = 1'b1;
        w_tmo_nxt      = TMO_W'(1);
        w_state_nxt    = S_RCML_WAIT;
      end
      // Both wait states share completion/timeout handling; only the
      // follow-on state and retry target differ.
      S_RCML_WAIT, S_RSET_WAIT: begin
        if (w_done) begin
          w_retry_nxt = '0;
          if (r_state == S_RCML_WAIT) begin
            w_ch_nxt    = w_last ? '0 : r_ch + CH_W'(1);
            w_state_nxt = w_last ? S_RSET_SCAN : S_RCML_START;
          end else begin
            w_ch_nxt    = w_last ? r_ch : r_ch + CH_W'(1);
            w_state_nxt = w_last ? S_IDLE : S_RSET_SCAN;
          end
        end else if (w_tmo_hit) begin
          if (r_retry < RETRY_MAX) begin
            w_retry_nxt = r_retry + RETRY_W'(1);
            w_state_nxt = (r_state == S_RCML_WAIT) ? S_RCML_START : S_RSET_START;
          end else begin
            w_cfg_error_nxt = 1'b1;
            w_err_ch_nxt    = 3'(r_ch);
            w_state_nxt     = S_ERROR;
          end
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      S_RSET_SCAN: begin
        if (r_mask[r_ch]) begin
          w_shadow_nxt[r_ch*FSADJ_W +: FSADJ_W] = dac_fsadj[r_ch*FSADJ_W +: FSADJ_W];
          w_state_nxt = S_RSET_START;
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ch_nxt = r_ch + CH_W'(1);
        end
      end
      S_RSET_START: begin
        w_spi_reg_nxt  = RSET_ADDRS[r_ch*ADDR_W +: ADDR_W];
        w_spi_data_nxt = w_rset_data;
        w_spi_send_nxt = 1'b1;
        w_tmo_nxt      = TMO_W'(1);
        w_state_nxt    = S_RSET_WAIT;
      end
      S_IDLE: begin
        if (r_pend) begin
          w_pend_nxt  = force_reinit;
          w_state_nxt = S_BEGIN;
        end else if (w_changed != '0) begin
          w_mask_nxt  = w_changed;
          w_ch_nxt    = '0;
          w_state_nxt = S_RSET_SCAN;
        end
      end
      S_ERROR: begin
        if (r_pend) begin
          w_pend_nxt      = force_reinit;
          w_cfg_error_nxt = 1'b0;
          w_state_nxt     = S_BEGIN;
        end
      end
      default: w_state_nxt = S_BEGIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_BEGIN;
      r_ch        <= '0;
      r_mask      <= '0;
      r_shadow    <= '0;
      r_retry     <= '0;
      r_tmo       <= '0;
      r_spi_reg   <= '0;
      r_spi_data  <= '0;
      r_spi_send  <= 1'b0;
      r_cfg_error <= 1'b0;
      r_err_ch    <= '0;
      r_pend      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ch        <= w_ch_nxt;
      r_mask      <= w_mask_nxt;
      r_shadow    <= w_shadow_nxt;
      r_retry     <= w_retry_nxt;
      r_tmo       <= w_tmo_nxt;
      r_spi_reg   <= w_spi_reg_nxt;
      r_spi_data  <= w_spi_data_nxt;
      r_spi_send  <= w_spi_send_nxt;
      r_cfg_error <= w_cfg_error_nxt;
      r_err_ch    <= w_err_ch_nxt;
      r_pend      <= w_pend_nxt;
    end
  end

  assign spi.spi_reg     = r_spi_reg;
  assign spi.spi_data_in = r_spi_data;
  assign spi.spi_send    = r_spi_send;
  assign spi.spi_rw      = 1'b0;
  assign dac_ready       = (r_state == S_IDLE);
  assign cfg_error       = r_cfg_error;
  assign err_ch          = r_err_ch;

endmodule

// File: tb/tb_dac_cfg_sequencer.sv
// Directed bench for dac_cfg_sequencer: SPI responder logs every strobe,
// each test task compares the logged writes and status outputs inline.
module tb_dac_cfg_sequencer;

  logic        clk;
  logic        reset_n;
  logic [11:0] dac_fsadj;
  logic        force_reinit;
  logic        dac_ready;
  logic        cfg_error;
  logic [2:0]  err_ch;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit dead = 1'b0;
  int cnt = 0;
  int send_viol = 0;
  logic prev_send = 1'b0;

  logic [5:0] log_reg[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];
  logic       log_rdy[$];

  dac_cfg_sequencer_if #(.ADDR_W(6), .DATA_W(8)) spi ();

  dac_cfg_sequencer #(
    .NUM_CH(2), .FSADJ_W(6), .ADDR_W(6), .DATA_W(8),
    .RCML_ADDRS({6'h08, 6'h05}), .RSET_ADDRS({6'h07, 6'h04}),
    .RCML_DATA(8'h80), .TIMEOUT_CYC(16), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dac_fsadj(dac_fsadj),
    .force_reinit(force_reinit), .spi(spi),
    .dac_ready(dac_ready), .cfg_error(cfg_error), .err_ch(err_ch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI master model: done drops at the strobe and returns 4 cycles later
  initial begin
    spi.spi_done = 1'b1;
    forever begin
      @(negedge clk);
      if (spi.spi_send === 1'b1) begin
        log_reg.push_back(spi.spi_reg);
        log_data.push_back(spi.spi_data_in);
        log_cyc.push_back(cyc);
        log_rdy.push_back(dac_ready);
        if (prev_send === 1'b1) send_viol++;
      end
      prev_send = spi.spi_send;
      if (dead) begin
        spi.spi_done = 1'b0;
        cnt = 0;
      end else if (spi.spi_send === 1'b1) begin
        spi.spi_done = 1'b0;
        cnt = 4;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) spi.spi_done = 1'b1;
      end else begin
        spi.spi_done = 1'b1;
      end
    end
  end

  task automatic clear_log();
    log_reg.delete();
    log_data.delete();
    log_cyc.delete();
    log_rdy.delete();
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (log_reg.size() < n && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    if (log_reg.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_log: got %0d writes, required %0d", log_reg.size(), n);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (dac_ready !== 1'b1 && k < 400);
    if (dac_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready: dac_ready never rose");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (spi.spi_send !== 1'b0) begin errors++; $display("FAIL rst_send: got %b exp 0", spi.spi_send); end
    checks++; if (spi.spi_reg !== 6'h00) begin errors++; $display("FAIL rst_reg: got %h exp 00", spi.spi_reg); end
    checks++; if (spi.spi_data_in !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", spi.spi_data_in); end
    checks++; if (dac_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", dac_ready); end
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", cfg_error); end
    checks++; if (err_ch !== 3'd0) begin errors++; $display("FAIL rst_errch: got %0d exp 0", err_ch); end
  endtask

  task automatic test_init();
    logic [5:0] er[4] = '{6'h05, 6'h08, 6'h04, 6'h07};
    logic [7:0] ed[4] = '{8'h80, 8'h80, 8'h85, 8'h92};
    clear_log();
    @(negedge clk); #1;
    reset_n = 1'b1;
    wait_log(4);
    wait_ready();
    checks++; if (log_reg.size() !== 4) begin errors++; $display("FAIL init_count: got %0d exp 4", log_reg.size()); end
    for (int i = 0; i < 4 && i < log_reg.size(); i++) begin
      checks++;
      if (log_reg[i] !== er[i] || log_data[i] !== ed[i]) begin
        errors++; $display("FAIL init_write%0d: got (%h,%h) exp (%h,%h)", i, log_reg[i], log_data[i], er[i], ed[i]);
      end
    end
    checks++; if (dac_ready !== 1'b1) begin errors++; $display("FAIL init_ready: got %b exp 1", dac_ready); end
  endtask

  task automatic test_single_change();
    clear_log();
    @(negedge clk); #1;
    dac_fsadj[11:6] = 6'h3F;
    wait_log(1);
    wait_ready();
    repeat (8) @(negedge clk);
    checks++; if (log_reg.size() !== 1) begin errors++; $display("FAIL single_count: got %0d exp 1", log_reg.size()); end
    if (log_reg.size() > 0) begin
      checks++;
      if (log_reg[0] !== 6'h07 || log_data[0] !== 8'hBF) begin
        errors++; $display("FAIL single_write: got (%h,%h) exp (07,bf)", log_reg[0], log_data[0]);
      end
      checks++; if (log_rdy[0] !== 1'b0) begin errors++; $display("FAIL single_busy: ready %b during write, exp 0", log_rdy[0]); end
    end
    checks++; if (dac_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", dac_ready); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    @(negedge clk); #1;
    dac_fsadj[11:6] = 6'h2A;
    wait_log(1);
    dac_fsadj[5:0] = 6'h11;
    wait_log(2);
    wait_ready();
    repeat (4) @(negedge clk);
    checks++; if (log_reg.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d exp 2", log_reg.size()); end
    if (log_reg.size() >= 2) begin
      checks++;
      if (log_reg[0] !== 6'h07 || log_data[0] !== 8'hAA) begin
        errors++; $display("FAIL b2b_ch1: got (%h,%h) exp (07,aa)", log_reg[0], log_data[0]);
      end
      checks++;
      if (log_reg[1] !== 6'h04 || log_data[1] !== 8'h91) begin
        errors++; $display("FAIL b2b_ch0: got (%h,%h) exp (04,91)", log_reg[1], log_data[1]);
      end
    end
  endtask

  task automatic test_latency();
    int c0;
    clear_log();
    @(negedge clk); #1;
    c0 = cyc;
    dac_fsadj[5:0] = 6'h00;
    wait_log(1);
    wait_ready();
    if (log_reg.size() > 0) begin
      checks++;
      if (log_cyc[0] !== c0 + 3) begin
        errors++; $display("FAIL latency: strobe at cycle %0d exp %0d", log_cyc[0], c0 + 3);
      end
      checks++;
      if (log_reg[0] !== 6'h04 || log_data[0] !== 8'h80) begin
        errors++; $display("FAIL zero_code: got (%h,%h) exp (04,80)", log_reg[0], log_data[0]);
      end
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    dead = 1'b1;
    clear_log();
    @(negedge clk); #1;
    dac_fsadj[11:6] = 6'h01;
    while (cfg_error !== 1'b1 && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (20) @(negedge clk);
    checks++; if (log_reg.size() !== 4) begin errors++; $display("FAIL tmo_count: got %0d strobes exp 4", log_reg.size()); end
    for (int i = 0; i < 4 && i < log_reg.size(); i++) begin
      checks++;
      if (log_reg[i] !== 6'h07 || log_data[i] !== 8'h81) begin
        errors++; $display("FAIL tmo_write%0d: got (%h,%h) exp (07,81)", i, log_reg[i], log_data[i]);
      end
    end
    for (int i = 1; i < 4 && i < log_reg.size(); i++) begin
      checks++;
      if (log_cyc[i] - log_cyc[i-1] !== 16) begin
        errors++; $display("FAIL tmo_spacing%0d: got %0d exp 16", i, log_cyc[i] - log_cyc[i-1]);
      end
    end
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b exp 1", cfg_error); end
    checks++; if (err_ch !== 3'd1) begin errors++; $display("FAIL tmo_errch: got %0d exp 1", err_ch); end
    checks++; if (dac_ready !== 1'b0) begin errors++; $display("FAIL tmo_ready: got %b exp 0", dac_ready); end
  endtask

  task automatic test_reinit();
    logic [5:0] er[4] = '{6'h05, 6'h08, 6'h04, 6'h07};
    logic [7:0] ed[4] = '{8'h80, 8'h80, 8'h80, 8'h81};
    dead = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", cfg_error); end
    clear_log();
    #1 force_reinit = 1'b1;
    @(negedge clk); #1;
    force_reinit = 1'b0;
    wait_log(4);
    wait_ready();
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reinit_err: got %b exp 0", cfg_error); end
    checks++; if (log_reg.size() !== 4) begin errors++; $display("FAIL reinit_count: got %0d exp 4", log_reg.size()); end
    for (int i = 0; i < 4 && i < log_reg.size(); i++) begin
      checks++;
      if (log_reg[i] !== er[i] || log_data[i] !== ed[i]) begin
        errors++; $display("FAIL reinit_write%0d: got (%h,%h) exp (%h,%h)", i, log_reg[i], log_data[i], er[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] er[4] = '{6'h05, 6'h08, 6'h04, 6'h07};
    logic [7:0] ed[4] = '{8'h80, 8'h80, 8'h80, 8'hA2};
    clear_log();
    @(negedge clk); #1;
    dac_fsadj[11:6] = 6'h22;
    wait_log(1);
    @(negedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk); #1;
    checks++; if (spi.spi_send !== 1'b0) begin errors++; $display("FAIL mid_send: got %b exp 0", spi.spi_send); end
    checks++; if (spi.spi_reg !== 6'h00) begin errors++; $display("FAIL mid_reg: got %h exp 00", spi.spi_reg); end
    checks++; if (spi.spi_data_in !== 8'h00) begin errors++; $display("FAIL mid_data: got %h exp 00", spi.spi_data_in); end
    checks++; if (dac_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b exp 0", dac_ready); end
    checks++; if (err_ch !== 3'd0) begin errors++; $display("FAIL mid_errch: got %0d exp 0", err_ch); end
    clear_log();
    reset_n = 1'b1;
    wait_log(4);
    wait_ready();
    checks++; if (log_reg.size() !== 4) begin errors++; $display("FAIL mid_count: got %0d exp 4", log_reg.size()); end
    for (int i = 0; i < 4 && i < log_reg.size(); i++) begin
      checks++;
      if (log_reg[i] !== er[i] || log_data[i] !== ed[i]) begin
        errors++; $display("FAIL mid_write%0d: got (%h,%h) exp (%h,%h)", i, log_reg[i], log_data[i], er[i], ed[i]);
      end
    end
  endtask

  task automatic test_protocol();
    checks++; if (send_viol !== 0) begin errors++; $display("FAIL send_width: got %0d multi-cycle strobes exp 0", send_viol); end
    checks++; if (spi.spi_rw !== 1'b0) begin errors++; $display("FAIL spi_rw: got %b exp 0", spi.spi_rw); end
  endtask

  initial begin
    reset_n      = 1'b0;
    dac_fsadj    = {6'h12, 6'h05};
    force_reinit = 1'b0;
    test_reset();
    test_init();
    test_single_change();
    test_back_to_back();
    test_latency();
    test_timeout();
    test_reinit();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_cfg_sequencer.md
Name: dac_cfg_sequencer

Overview:
- Parametrised, multi-channel successor to the single-DAC SPI register configuration controller.
- Sits between the user amplitude controls and the DAC SPI master.
- After reset, writes every channel's RCML and RSET registers.
- Afterwards, rewrites only the RSET registers of channels whose FSADJ value changed.
- Adds an SPI completion timeout with bounded retry, a sticky error flag, and a software re-init request.

Parameters:
- NUM_CH, 2, number of DAC channels (1..8)
- FSADJ_W, 6, FSADJ code width per channel (must be <= DATA_W-1)
- ADDR_W, 6, SPI register address width
- DATA_W, 8, SPI data width
- RCML_ADDRS, {6'h08,6'h05}, packed per-channel RCML register addresses; channel 0 in the LSBs
- RSET_ADDRS, {6'h07,6'h04}, packed per-channel RSET register addresses; channel 0 in the LSBs
- RCML_DATA, 8'h80, value written to each RCML register (internal 60 Ohm)
- TIMEOUT_CYC, 4096, cycles to wait for spi_done before retrying a write
- MAX_RETRY, 3, retries per write before declaring an error

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- dac_fsadj  in  NUM_CH*FSADJ_W  packed per-channel FSADJ codes; channel 0 in the LSBs
- force_reinit  in  1  one-cycle request to rerun the full init sequence
- spi_reg  out  ADDR_W  register address to the SPI master
- spi_data_in  out  DATA_W  write data to the SPI master
- spi_send  out  1  one-cycle write strobe
- spi_done  in  1  level signal: SPI master idle/complete
- spi_rw  out  1  constant 0 (write only)
- dac_ready  out  1  high while every channel matches its shadow and no write is pending
- cfg_error  out  1  sticky: a write exhausted its retries
- err_ch  out  3  channel index of the failed write

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - spi_reg=0, spi_data_in=0, spi_send=0, dac_ready=0, cfg_error=0, err_ch=0.
  - Shadow registers cleared, retry and timeout counters cleared, pending re-init cleared.
  - State goes to S_BEGIN.
  - Reset asserted mid-write abandons that write immediately.
- States:
  - S_BEGIN: set mask to all ones, ch=0, go to S_RCML_START.
  - S_RCML_START: drive spi_reg=RCML_ADDRS[ch], spi_data_in=RCML_DATA, spi_send=1; go to S_RCML_WAIT.
  - S_RCML_WAIT: on completion, ch++; after the last channel, go to S_RSET_SCAN with ch=0.
  - S_RSET_SCAN:
    - Skip channels whose mask bit is 0.
    - For a channel whose mask bit is 1, capture the snapshot: shadow[ch]<=dac_fsadj[ch].
    - Go to S_RSET_START.
    - After NUM_CH-1 has been scanned, go to S_IDLE.
  - S_RSET_START: drive spi_reg=RSET_ADDRS[ch], spi_data_in=8'h80 | zero-extended shadow[ch], spi_send=1; go to S_RSET_WAIT.
  - S_RSET_WAIT: on completion, ch++ and return to S_RSET_SCAN.
  - S_IDLE:
    - dac_ready=1.
    - Pending force_reinit has priority: go to S_BEGIN.
    - Otherwise, if any dac_fsadj[c] != shadow[c], set mask to the changed bits, ch=0, go to S_RSET_SCAN.
    - dac_ready=0 from the cycle after the change is sampled.
  - S_ERROR:
    - dac_ready=0, cfg_error=1.
    - Exit only via force_reinit, which also clears cfg_error, or via reset.
- Handshake:
  - spi_send is high for exactly one cycle per write.
  - spi_done is ignored while spi_send=1.
  - Completion = first cycle with spi_done=1 and spi_send=0.
  - spi_reg and spi_data_in hold stable from the strobe until completion.
- Timeout and retry:
  - The timeout counter starts at the strobe and counts every WAIT cycle.
  - At TIMEOUT_CYC with no completion: if retries < MAX_RETRY, increment retries and reissue the same write (back to the *_START state).
  - Otherwise set err_ch=ch and go to S_ERROR.
  - The retry count clears on each completed write.
- Snapshot semantics:
  - FSADJ changes during an update are not lost; they are detected on the next S_IDLE comparison.
  - A channel that changes back to its shadow value before being scanned is still written, because its mask bit is already set.
- force_reinit:
  - Sampled every cycle into a pending flag.
  - Acted on only in S_IDLE or S_ERROR; never aborts an in-flight write.
- Latency: a change sampled in S_IDLE at cycle t produces spi_send at t+3 (SCAN, START, strobe).

Test Plan:
- Release reset with fsadj={6'h12,6'h05} and spi_done returned 4 cycles after each strobe -> writes (05,80), (08,80), (04,85), (07,92) in that order; then dac_ready=1.
- In IDLE, change only ch1 to 6'h3F -> exactly one write (07,BF); dac_ready low during the write, high after; no ch0 write.
- Change ch0 during the ch1 RSET write -> the ch1 write completes with its snapshot value, then a separate (04,80|new) write follows.
- Hold spi_done=0 with TIMEOUT_CYC=16 and MAX_RETRY=3 -> 4 identical strobes 16 cycles apart; then cfg_error=1, err_ch=current channel, dac_ready=0.
- From the error state, pulse force_reinit with spi_done healthy -> cfg_error clears and the full 2*NUM_CH write init sequence reruns.
- Assert reset_n=0 mid-RSET-wait -> all outputs at reset values next cycle; after release, the init sequence restarts from the RCML write for ch0.
